// File: rtl/rtc_time_keeper.sv
// Real-time clock core: loads BCD date/time and advances it once per
// second with full calendar, leap-year and weekday rollover.
module rtc_time_keeper #(
  parameter int CLK_HZ = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] set_year,
  input  logic [7:0]  set_month,
  input  logic [7:0]  set_day,
  input  logic [7:0]  set_hour,
  input  logic [7:0]  set_minute,
  input  logic [7:0]  set_sec,
  input  logic [3:0]  set_week,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  sec,
  output logic [3:0]  week,
  output logic        sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          leap;
  logic [7:0]    last_day;
  logic          c_min, c_hour, c_day, c_month, c_year;
  logic [15:0]   n_year;
  logic [7:0]    n_month, n_day, n_hour, n_minute, n_sec;
  logic [3:0]    n_week;

  function automatic logic [7:0] inc8(input logic [7:0] v);
    if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [15:0] inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'h9) begin
          r[i*4 +: 4] = 4'h0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'h1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Divisible-by-4 test straight on two BCD digits.
  function automatic logic div4(input logic [7:0] v);
    if (v[4])
      return (v[3:0] == 4'h2) || (v[3:0] == 4'h6);
    return (v[3:0] == 4'h0) || (v[3:0] == 4'h4) ||
           (v[3:0] == 4'h8);
  endfunction

  assign tick = run && (presc == TC);
  assign leap = div4((year[7:0] == 8'h00) ? year[15:8] : year[7:0]);

  always_comb begin
    last_day = 8'h31;
    unique case (1'b1)
      (month == 8'h02): last_day = leap ? 8'h29 : 8'h28;
      (month == 8'h04), (month == 8'h06),
      (month == 8'h09), (month == 8'h11): last_day = 8'h30;
      default: last_day = 8'h31;
    endcase
  end

  always_comb begin
    c_min    = sec >= 8'h59;
    c_hour   = c_min && (minute >= 8'h59);
    c_day    = c_hour && (hour >= 8'h23);
    c_month  = c_day && (day >= last_day);
    c_year   = c_month && (month >= 8'h12);
    n_sec    = c_min ? 8'h00 : inc8(sec);
    n_minute = minute;
    n_hour   = hour;
    n_day    = day;
    n_month  = month;
    n_year   = year;
    n_week   = week;
    if (c_min)
      n_minute = c_hour ? 8'h00 : inc8(minute);
    if (c_hour)
      n_hour = c_day ? 8'h00 : inc8(hour);
    if (c_day) begin
      n_day  = c_month ? 8'h01 : inc8(day);
      n_week = (week >= 4'd6) ? 4'd0 : week + 4'd1;
    end
    if (c_month)
      n_month = c_year ? 8'h01 : inc8(month);
    if (c_year)
      n_year = inc16(year);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      year     <= 16'h2023;
      month    <= 8'h01;
      day      <= 8'h01;
      hour     <= 8'h00;
      minute   <= 8'h00;
      sec      <= 8'h00;
      week     <= 4'd0;
    end else begin
      sec_tick <= 1'b0;
      if (load) begin
        presc  <= '0;
        year   <= set_year;
        month  <= set_month;
        day    <= set_day;
        hour   <= set_hour;
        minute <= set_minute;
        sec    <= set_sec;
        week   <= set_week;
      end else if (tick) begin
        presc    <= '0;
        sec_tick <= 1'b1;
        year     <= n_year;
        month    <= n_month;
        day      <= n_day;
        hour     <= n_hour;
        minute   <= n_minute;
        sec      <= n_sec;
        week     <= n_week;
      end else if (run) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Bench for rtc_time_keeper: directed calendar corners plus random
// loads/run patterns against an integer calendar model.
module tb_rtc_time_keeper;

  localparam int HZ = 4;

  logic        clk, rst, run, load;
  logic [15:0] set_year;
  logic [7:0]  set_month, set_day, set_hour, set_minute, set_sec;
  logic [3:0]  set_week;
  logic [15:0] year;
  logic [7:0]  month, day, hour, minute, sec;
  logic [3:0]  week;
  logic        sec_tick;

  int tests, fails;
  int m_yr, m_mo, m_dy, m_hr, m_mi, m_se, m_wk, m_cnt;
  bit m_tick;

  rtc_time_keeper #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst(rst), .run(run), .load(load),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_minute(set_minute), .set_sec(set_sec),
    .set_week(set_week),
    .year(year), .month(month), .day(day), .hour(hour),
    .minute(minute), .sec(sec), .week(week), .sec_tick(sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] b2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] b4(input int v);
    return {b2(v / 100), b2(v % 100)};
  endfunction

  function automatic int dim(input int mo, input int yr);
    bit lp;
    lp = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
    case (mo)
      2: return lp ? 29 : 28;
      4, 6, 9, 11: return 30;
      default: return 31;
    endcase
  endfunction

  task automatic m_reset();
    m_yr = 2023; m_mo = 1; m_dy = 1;
    m_hr = 0; m_mi = 0; m_se = 0; m_wk = 0;
    m_cnt = 0; m_tick = 0;
  endtask

  task automatic m_advance();
    if (m_se >= 59) begin
      m_se = 0;
      if (m_mi >= 59) begin
        m_mi = 0;
        if (m_hr >= 23) begin
          m_hr = 0;
          m_wk = (m_wk >= 6) ? 0 : m_wk + 1;
          if (m_dy >= dim(m_mo, m_yr)) begin
            m_dy = 1;
            if (m_mo >= 12) begin
              m_mo = 1;
              m_yr = (m_yr + 1) % 10000;
            end else m_mo++;
          end else m_dy++;
        end else m_hr++;
      end else m_mi++;
    end else m_se++;
  endtask

  task automatic check(input string tag);
    logic [68:0] obs, exp;
    obs = {year, month, day, hour, minute, sec, week, sec_tick};
    exp = {b4(m_yr), b2(m_mo), b2(m_dy), b2(m_hr), b2(m_mi),
           b2(m_se), 4'(m_wk), m_tick};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model from the inputs seen at the edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    m_tick = 0;
    if (load) begin
      m_yr = int'(set_year[15:12]) * 1000 + int'(set_year[11:8]) * 100
           + int'(set_year[7:4]) * 10 + int'(set_year[3:0]);
      m_mo = int'(set_month[7:4]) * 10 + int'(set_month[3:0]);
      m_dy = int'(set_day[7:4]) * 10 + int'(set_day[3:0]);
      m_hr = int'(set_hour[7:4]) * 10 + int'(set_hour[3:0]);
      m_mi = int'(set_minute[7:4]) * 10 + int'(set_minute[3:0]);
      m_se = int'(set_sec[7:4]) * 10 + int'(set_sec[3:0]);
      m_wk = int'(set_week);
      m_cnt = 0;
    end else if (run) begin
      if (m_cnt == HZ - 1) begin
        m_cnt = 0;
        m_tick = 1;
        m_advance();
      end else m_cnt++;
    end
    #1;
    check(tag);
  endtask

  task automatic do_load(input int yr, mo, dy, hr, mi, se, wk,
                         input string tag);
    set_year = b4(yr); set_month = b2(mo); set_day = b2(dy);
    set_hour = b2(hr); set_minute = b2(mi); set_sec = b2(se);
    set_week = 4'(wk);
    load = 1'b1;
    cyc(tag);
    load = 1'b0;
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; run = 1'b0; load = 1'b0;
    set_year = '0; set_month = '0; set_day = '0; set_hour = '0;
    set_minute = '0; set_sec = '0; set_week = '0;
    m_reset();
    #12;
    check("reset_init");
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    run_n(6, "free_run");
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check("reset_async");
    @(negedge clk);
    rst = 1'b0;

    do_load(2023, 12, 31, 23, 59, 59, 6, "ny_load");
    run_n(4, "new_year");
    run_n(4, "new_year_next");
    do_load(2024, 2, 28, 23, 59, 59, 3, "leap24_load");
    run_n(4, "leap24_feb29");
    do_load(2024, 2, 29, 23, 59, 59, 4, "leap24b_load");
    run_n(4, "leap24_mar1");
    do_load(2100, 2, 28, 23, 59, 59, 0, "y2100_load");
    run_n(4, "y2100_mar1");
    do_load(2000, 2, 28, 23, 59, 59, 1, "y2000_load");
    run_n(4, "y2000_feb29");
    do_load(2023, 4, 30, 23, 59, 59, 0, "apr_load");
    run_n(4, "apr_may1");

    do_load(2023, 6, 15, 12, 0, 0, 4, "prio_pre");
    run_n(3, "prio_count");
    do_load(2023, 6, 15, 12, 30, 10, 4, "prio_load_tc");
    run_n(4, "prio_next_tick");

    run_n(2, "hold_pre");
    run = 1'b0;
    run_n(10, "hold");
    run = 1'b1;
    run_n(4, "hold_resume");

    do_load(9999, 12, 31, 23, 59, 59, 5, "wrap_load");
    run_n(4, "wrap_0000");

    set_year = 16'h2023; set_month = 8'h01; set_day = 8'h01;
    set_hour = 8'h10; set_minute = 8'h75; set_sec = 8'h59;
    set_week = 4'd2;
    load = 1'b1;
    cyc("oor_load");
    load = 1'b0;
    run_n(4, "oor_minute");

    for (int k = 0; k < 30; k++) begin
      int yr, mo;
      yr = $urandom_range(0, 9999);
      mo = $urandom_range(1, 12);
      do_load(yr, mo, $urandom_range(dim(mo, yr) - 1, dim(mo, yr)),
              ($urandom % 2) ? 23 : $urandom_range(0, 23),
              ($urandom % 2) ? 59 : $urandom_range(0, 59),
              $urandom_range(50, 59), $urandom_range(0, 6), "rnd_load");
      for (int j = 0; j < int'($urandom_range(10, 60)); j++) begin
        run = ($urandom % 4) != 0;
        cyc("rnd_run");
      end
      run = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
